// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants.
package cpu_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ex_sched_state_t;

endpackage

// File: rtl/ex_stage_sched.sv
// EX-stage scheduler: multi-cycle multiply occupancy, RAW hazard stall,
// taken-branch flush bubbling and a saturating stall-cycle counter.
module ex_stage_sched
    import cpu_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_valid,
    input  logic        ex_mul_v_alu,
    input  logic        ex_wr_en,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        stall_if_id,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        mul_start,
    output logic        mul_done,
    output logic        ex_busy,
    output logic [15:0] stall_cnt
);

    localparam int unsigned CNT_W = 4;

    ex_sched_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic raw_hazard;
    logic advance;

    assign raw_hazard = id_valid & ex_valid & ex_wr_en & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs) | (ex_rd == id_rt));

    assign ex_busy   = (state_q == MUL_BUSY);
    assign stall_cnt = stall_cnt_q;

    // Next state and pipeline control outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        stall_if_id  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        mul_start    = 1'b0;
        mul_done     = 1'b0;
        advance      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && ex_mul_v_alu) begin
                    mul_start   = 1'b1;
                    stall_if_id = 1'b1;
                    cnt_d       = CNT_W'(MUL_LAT - 2);
                    state_d     = MUL_BUSY;
                    if (flush) flush_pend_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    stall_if_id = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (flush) flush_pend_d = 1'b1;
                end else begin
                    mul_done = 1'b1;
                    advance  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pending flush outranks a hazard: the younger instruction is dead anyway.
        if (advance) begin
            id_ex_en = 1'b1;
            if (flush || flush_pend_q) begin
                id_ex_bubble = 1'b1;
                flush_pend_d = 1'b0;
            end else if (raw_hazard) begin
                id_ex_bubble = 1'b1;
                stall_if_id  = 1'b1;
            end else begin
                id_ex_bubble = ~id_valid;
            end
        end

        if (reset) begin
            stall_if_id  = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_bubble = 1'b0;
            mul_start    = 1'b0;
            mul_done     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_if_id && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: doc/ex_stage_sched.md
EX_STAGE_SCHED -- requirements
Module: ex_stage_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning total EX-stage cycles of a multiply (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-005 SHALL have port id_rs, id_rt  input  5 each  ID source register numbers.
REQ-006 SHALL have port ex_valid  input  1  EX stage (ID/EX register) holds a real instruction.
REQ-007 SHALL have port ex_mul_v_alu  input  1  EX instruction is a multiply (1) or ALU op (0).
REQ-008 SHALL have port ex_wr_en, ex_rd  input  1, 5  EX instruction writes register ex_rd.
REQ-009 SHALL have port flush  input  1  taken-branch flush request from EX.
REQ-010 SHALL have port stall_if_id  output  1  hold PC and IF/ID register.
REQ-011 SHALL have port id_ex_en  output  1  load the ID/EX register this cycle.
REQ-012 SHALL have port id_ex_bubble  output  1  when loading, load NOP (opcode NA) instead of ID values.
REQ-013 SHALL have ports mul_start, mul_done  output  1 each  single-cycle multiply start and finish pulses.
REQ-014 SHALL have port ex_busy  output  1  high while state is MUL_BUSY.
REQ-015 SHALL have port stall_cnt  output  16  saturating count of cycles with stall_if_id=1.

Function
REQ-016 SHALL implement states IDLE and MUL_BUSY, a down-counter cnt of 4 bits and a flush_pend flag.
REQ-017 SHALL compute raw_hazard = id_valid & ex_valid & ex_wr_en & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt).
REQ-018 SHALL, in IDLE with ex_valid & ex_mul_v_alu: assert mul_start, stall_if_id=1, id_ex_en=0, set cnt=MUL_LAT-2, go to MUL_BUSY.
REQ-019 SHALL, in MUL_BUSY with cnt!=0: assert stall_if_id=1, id_ex_en=0, decrement cnt.
REQ-020 SHALL, in MUL_BUSY with cnt==0: assert mul_done, apply the advance rules (REQ-021), go to IDLE.
REQ-021 SHALL, when advancing, use this priority: (flush|flush_pend) -> id_ex_en=1, bubble=1, stall_if_id=0, clear flush_pend; else raw_hazard -> id_ex_en=1, bubble=1, stall_if_id=1; else id_ex_en=1, bubble=!id_valid, stall_if_id=0.
REQ-022 SHALL, in IDLE without a multiply in EX, apply the advance rules every cycle.
REQ-023 SHALL latch flush into flush_pend when it is asserted in MUL_BUSY or on a mul_start cycle, and apply it no earlier than the mul_done cycle.
REQ-024 SHALL give a multiply exactly MUL_LAT cycles in EX: mul_start at cycle 0, mul_done at cycle MUL_LAT-1, stall_if_id high on cycles 0..MUL_LAT-2.
REQ-025 SHALL increment stall_cnt on each cycle with stall_if_id=1, saturating at 16'hFFFF and never wrapping.
REQ-026 SHALL drive all outputs combinationally from state, cnt, flush_pend and inputs, with no extra latency.

Reset
REQ-027 SHALL, on a cycle with reset=1, load state=IDLE, cnt=0, flush_pend=0 and stall_cnt=0 at the next edge.
REQ-028 SHALL force stall_if_id, id_ex_en, id_ex_bubble, mul_start and mul_done to 0 while reset=1.
REQ-029 SHALL abandon an in-flight multiply on reset without asserting mul_done.

Structure
REQ-030 SHALL place the ex_sched_state_t enum (IDLE, MUL_BUSY) and the MUL_LAT default constant in cpu_pkg.
REQ-031 SHALL be a single module with no sub-modules; the ID/EX register remains external and is driven by id_ex_en and id_ex_bubble.

Verification
REQ-032 SHALL cover multiply timing: MUL_LAT=4, ex_valid=1, ex_mul_v_alu=1 at cycle 0 -> mul_start at cycle 0, stall_if_id at cycles 0-2, mul_done with id_ex_en=1 at cycle 3, stall_cnt=3.
REQ-033 SHALL cover RAW hazards: ex_wr_en=1, ex_rd=5, id_rs=5 -> one cycle with id_ex_bubble=1 and stall_if_id=1; repeated with ex_rd=0 -> no stall.
REQ-034 SHALL cover flush during a multiply: flush pulsed at MUL_BUSY cycle 1 -> no bubble before cycle 3; at cycle 3 id_ex_bubble=1, stall_if_id=0, then flush_pend=0.
REQ-035 SHALL cover reset mid-multiply: reset at cycle 2 -> at cycle 3 ex_busy=0, mul_done never pulses, stall_cnt=0.
REQ-036 SHALL cover counter saturation: 65540 consecutive stall cycles -> stall_cnt holds 16'hFFFF.
REQ-037 SHALL cover empty ID: id_valid=0, no hazard, no flush -> id_ex_en=1, id_ex_bubble=1.
